mips_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS five-stage pipeline, sitting directly upstream of the IF/ID register. It owns the PC, issues requests to a variable-latency instruction memory, and applies branch/jump redirects and hazard stalls. Each cycle it presents `PCsum`, `Instruction` and `IF_FLUSH`, which the IF/ID register captures on the next clock edge. It inserts a NOP bubble whenever no valid instruction is available, and drops wrong-path fetches after a redirect.

---
 rtl/mips_fetch_unit.sv | 105 ++++++++++
 tb/tb_mips_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction-fetch stage with variable-latency imem, redirects and stalls
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [31:0] BranchAddr,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCsum,
  output logic [31:0] Instruction,
  output logic        IF_FLUSH
);

  typedef enum logic [1:0] {RUN, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] stale_addr;
  logic [31:0] hold_instr;
  logic        redir;
  logic [31:0] target_raw;
  logic [31:0] target;

  assign redir      = (Jump | Branch) & PCWrite;
  assign target_raw = Jump ? JumpAddr : BranchAddr;
  assign target     = target_raw & 32'hFFFF_FFFC;
  assign PCsum      = pc + 32'd4;

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc;
    Instruction = 32'b0;
    IF_FLUSH    = 1'b1;
    if (!RST) begin
      case (state)
        RUN: begin
          imem_req    = 1'b1;
          Instruction = imem_rdata;
          IF_FLUSH    = redir | (PCWrite & ~imem_ready);
        end
        HOLD: begin
          Instruction = hold_instr;
          IF_FLUSH    = redir;
        end
        DISCARD: begin
          // Keep the wrong-path address on the bus until memory answers it.
          imem_req  = 1'b1;
          imem_addr = stale_addr;
          IF_FLUSH  = PCWrite;
        end
        default: begin
          IF_FLUSH = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= RESET_PC & 32'hFFFF_FFFC;
      state      <= RUN;
      hold_instr <= 32'b0;
      stale_addr <= 32'b0;
    end else begin
      case (state)
        RUN: begin
          if (redir) begin
            pc <= target;
            if (!imem_ready) begin
              stale_addr <= pc;
              state      <= DISCARD;
            end
          end else if (PCWrite) begin
            if (imem_ready) pc <= pc + 32'd4;
          end else if (imem_ready) begin
            hold_instr <= imem_rdata;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= RUN;
          end else if (PCWrite) begin
            pc    <= pc + 32'd4;
            state <= RUN;
          end
        end
        DISCARD: begin
          if (redir)      pc    <= target;
          if (imem_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - scoreboard bench for mips_fetch_unit with random memory latency
module tb_mips_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PCWrite = 1'b0;
  logic        Branch = 1'b0;
  logic [31:0] BranchAddr = 32'b0;
  logic        Jump = 1'b0;
  logic [31:0] JumpAddr = 32'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'b0;
  logic [31:0] PCsum;
  logic [31:0] Instruction;
  logic        IF_FLUSH;

  always #5 CLK = ~CLK;

  mips_fetch_unit #(.RESET_PC(32'h0000_0043)) dut (
    .CLK(CLK), .RST(RST), .PCWrite(PCWrite), .Branch(Branch), .BranchAddr(BranchAddr),
    .Jump(Jump), .JumpAddr(JumpAddr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PCsum(PCsum),
    .Instruction(Instruction), .IF_FLUSH(IF_FLUSH)
  );

  typedef struct packed {
    logic [31:0] pcsum;
    logic [31:0] instr;
  } deliv_t;

  deliv_t expq[$];
  deliv_t e;
  int     checks = 0;
  int     failures = 0;
  int     deliveries = 0;
  bit     started = 1'b0;

  // memory model state
  bit          pending = 1'b0;
  bit          cur_active = 1'b0;
  logic [31:0] paddr = 32'b0;
  int          cnt = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;

  // architectural reference state
  logic [31:0] exp_pc = 32'h40;
  bit          held = 1'b0;
  logic [31:0] held_word = 32'b0;
  bit          wrong = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h54) return 32'h2002_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic mem_step();
    cur_active = 1'b0;
    imem_ready = 1'b0;
    if (RST) begin
      pending = 1'b0;
    end else if (imem_req) begin
      cur_active = 1'b1;
      if (!pending) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = $urandom_range(lat_hi, lat_lo);
        check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'b0);
      end else begin
        check("addr_stable", imem_addr, paddr);
      end
      if (cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = memword(paddr);
        pending    = 1'b0;
      end else begin
        cnt--;
      end
    end else begin
      if (pending) begin
        checks++;
        failures++;
        $display("FAIL req_dropped actual=0 required=1");
      end
      pending    = 1'b0;
      imem_ready = ($urandom_range(3, 0) == 0);
      imem_rdata = $urandom;
    end
  endtask

  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    if (RST) begin
      exp_pc = 32'h40;
      held   = 1'b0;
      wrong  = 1'b0;
      return;
    end
    redir = PCWrite & (Branch | Jump);
    tgt   = (Jump ? JumpAddr : BranchAddr) & 32'hFFFF_FFFC;
    check("req", {31'b0, imem_req}, {31'b0, !held});
    if (cur_active && !wrong) check("fetch_addr", imem_addr, exp_pc);
    if (held) begin
      if (redir) begin
        held   = 1'b0;
        exp_pc = tgt;
      end else if (PCWrite) begin
        expq.push_back('{pcsum: exp_pc + 32'd4, instr: held_word});
        exp_pc = exp_pc + 32'd4;
        held   = 1'b0;
      end
    end else if (cur_active) begin
      if (wrong) begin
        if (imem_ready) wrong = 1'b0;
        if (redir) exp_pc = tgt;
      end else if (redir) begin
        exp_pc = tgt;
        if (!imem_ready) wrong = 1'b1;
      end else if (imem_ready) begin
        if (PCWrite) begin
          expq.push_back('{pcsum: exp_pc + 32'd4, instr: memword(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end else begin
          held      = 1'b1;
          held_word = memword(exp_pc);
        end
      end
    end
  endtask

  task automatic cycle(input logic rst_i, input logic pcw, input logic br, input logic [31:0] ba,
                       input logic jp, input logic [31:0] ja);
    @(posedge CLK);
    #1;
    RST = rst_i; PCWrite = pcw; Branch = br; BranchAddr = ba; Jump = jp; JumpAddr = ja;
    #1;
    mem_step();
    #1;
    model_step();
    started = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (started) begin
      if (RST) begin
        check("rst_flush", {31'b0, IF_FLUSH}, 32'd1);
        check("rst_instr", Instruction, 32'b0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
      end else begin
        if (PCWrite && (Branch || Jump)) check("redir_flush", {31'b0, IF_FLUSH}, 32'd1);
        if (!PCWrite) check("stall_no_flush", {31'b0, IF_FLUSH}, 32'd0);
        if (PCWrite && !IF_FLUSH) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_delivery actual=%h required=bubble", Instruction);
          end else begin
            e = expq.pop_front();
            check("instr", Instruction, e.instr);
            check("pcsum", PCsum, e.pcsum);
            deliveries++;
          end
        end
      end
      checks++;
      if (expq.size() != 0) begin
        failures++;
        $display("FAIL missed_delivery actual=bubble required=%h", expq[0].instr);
        expq.delete();
      end
    end
  end

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // single-cycle memory: 0x40, 0x44, 0x48
    lat_lo = 0; lat_hi = 0;
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    // 3-cycle memory: two bubbles per delivery
    lat_lo = 2; lat_hi = 2;
    repeat (6) cycle(0, 1, 0, 0, 0, 0);
    // stall while the word arrives, then release
    lat_lo = 0; lat_hi = 0;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // branch while a slow request is outstanding
    lat_lo = 2; lat_hi = 2;
    cycle(0, 1, 1, 32'h100, 0, 0);
    repeat (5) cycle(0, 1, 0, 0, 0, 0);
    // jump beats branch; stalled branch ignored; misaligned and wrapping targets
    lat_lo = 0; lat_hi = 0;
    cycle(0, 1, 1, 32'h100, 1, 32'h200);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h100, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 32'h203);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        pcw, br, jp, rs;
      logic [31:0] ba, ja;
      if (i % 200 == 0) begin
        lat_lo = 0;
        lat_hi = $urandom_range(3, 0);
      end
      rs  = ($urandom_range(499, 0) == 0);
      pcw = ($urandom_range(9, 0) < 8);
      br  = ($urandom_range(11, 0) == 0);
      jp  = ($urandom_range(23, 0) == 0);
      ba  = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFFC | {30'b0, 2'($urandom_range(3, 0))})
                                         : ($urandom & 32'h0000_0FFF);
      ja  = $urandom & 32'h0000_3FFF;
      cycle(rs, pcw, br, ba, jp, ja);
    end
    check("delivery_progress", {31'b0, (deliveries >= 200)}, 32'd1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
